// File: rtl/node_seq_if.sv
// Valid/ready operand and result bundle for the time-multiplexed neuron node.
// master drives operands and consumes results; slave is the node itself.
interface node_seq_if #(
   parameter int N_INPUTS    = 16,
   parameter int INPUT_BITS  = 6,
   parameter int WEIGHT_BITS = 6,
   parameter int SUM_BITS    = 16,
   parameter int OUTPUT_BITS = 1
);
   logic                            in_valid;
   logic                            in_ready;
   logic [N_INPUTS*INPUT_BITS-1:0]  inputs_t;
   logic [N_INPUTS*WEIGHT_BITS-1:0] weights_t;
   logic [WEIGHT_BITS-1:0]          bias_t;
   logic                            out_valid;
   logic                            out_ready;
   logic [OUTPUT_BITS-1:0]          outputs_t;
   logic [SUM_BITS-1:0]             sum_out;

   modport master (
      output in_valid, inputs_t, weights_t, bias_t, out_ready,
      input  in_ready, out_valid, outputs_t, sum_out
   );

   modport slave (
      input  in_valid, inputs_t, weights_t, bias_t, out_ready,
      output in_ready, out_valid, outputs_t, sum_out
   );
endinterface

// File: rtl/node_seq.sv
// Time-multiplexed neuron: act(bias + sum inputs*weights) using LANES multipliers
// per beat, N_INPUTS/LANES beats per sample, valid/ready on both sides.
//
// state | meaning
// IDLE  | waiting for an operand vector, in_ready=1
// ACC   | accumulating LANES products per clock
// DONE  | result held until out_ready
module node_seq #(
   parameter int N_INPUTS    = 16,
   parameter int LANES       = 4,
   parameter int WEIGHT_BITS = 6,
   parameter int INPUT_BITS  = 6,
   parameter int SUM_BITS    = 16,
   parameter int OUTPUT_BITS = 1,
   parameter int OUT_SHIFT   = 0
) (
   input logic         clk,
   input logic         reset,
   node_seq_if.slave   bus
);
   localparam int N_BEATS = N_INPUTS / LANES;
   localparam int BEAT_W  = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
   localparam int PROD_W  = INPUT_BITS + WEIGHT_BITS;
   localparam logic signed [SUM_BITS-1:0] SAT_MAX = SUM_BITS'((2 ** (OUTPUT_BITS - 1)) - 1);
   localparam logic signed [SUM_BITS-1:0] SAT_MIN = SUM_BITS'(-(2 ** (OUTPUT_BITS - 1)));
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N_BEATS - 1);

   typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

   state_t                          state, state_next;
   logic                            load, acc_en;
   logic [BEAT_W-1:0]               beat;
   logic signed [SUM_BITS-1:0]      acc, acc_next, lane_sum;
   logic [N_INPUTS*INPUT_BITS-1:0]  in_reg;
   logic [N_INPUTS*WEIGHT_BITS-1:0] w_reg;
   logic signed [PROD_W-1:0]        prod;
   logic                            out_valid;
   logic [OUTPUT_BITS-1:0]          outputs;
   logic [SUM_BITS-1:0]             sum_reg;

   function automatic logic [OUTPUT_BITS-1:0] act(input logic signed [SUM_BITS-1:0] s);
      logic signed [SUM_BITS-1:0] v;
      v = s >>> OUT_SHIFT;
      if (OUTPUT_BITS == 1)
         act = OUTPUT_BITS'(!s[SUM_BITS-1]);
      else if (v > SAT_MAX)
         act = SAT_MAX[OUTPUT_BITS-1:0];
      else if (v < SAT_MIN)
         act = SAT_MIN[OUTPUT_BITS-1:0];
      else
         act = v[OUTPUT_BITS-1:0];
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      load       = 1'b0;
      acc_en     = 1'b0;
      case (state)
         IDLE: if (bus.in_valid) begin
            load       = 1'b1;
            state_next = ACC;
         end
         ACC: begin
            acc_en = 1'b1;
            if (beat == LAST_BEAT) state_next = DONE;
         end
         DONE: if (bus.out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Products are formed at full width, then sign-extended into the wrapping accumulator.
   always_comb begin
      lane_sum = '0;
      prod     = '0;
      for (int l = 0; l < LANES; l++) begin
         prod = PROD_W'($signed(in_reg[(int'(beat) * LANES + l) * INPUT_BITS +: INPUT_BITS]))
              * PROD_W'($signed(w_reg[(int'(beat) * LANES + l) * WEIGHT_BITS +: WEIGHT_BITS]));
         lane_sum = lane_sum + SUM_BITS'(prod);
      end
      acc_next = acc + lane_sum;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         in_reg    <= '0;
         w_reg     <= '0;
         acc       <= '0;
         beat      <= '0;
         out_valid <= 1'b0;
         outputs   <= '0;
         sum_reg   <= '0;
      end else begin
         if (load) begin
            in_reg <= bus.inputs_t;
            w_reg  <= bus.weights_t;
            acc    <= SUM_BITS'($signed(bus.bias_t));
            beat   <= '0;
         end
         if (acc_en) begin
            acc  <= acc_next;
            beat <= beat + 1'b1;
            if (beat == LAST_BEAT) begin
               sum_reg   <= acc_next;
               outputs   <= act(acc_next);
               out_valid <= 1'b1;
               beat      <= '0;
            end
         end
         if (state == DONE && bus.out_ready) out_valid <= 1'b0;
      end
   end

   assign bus.in_ready  = (state == IDLE) && !reset;
   assign bus.out_valid = out_valid;
   assign bus.outputs_t = outputs;
   assign bus.sum_out   = sum_reg;
endmodule

// File: tb/tb_node_seq.sv
// Bench for node_seq: four configurations share one stimulus stream and are
// checked against a plain-arithmetic reference of the neuron.
module tb_node_seq;
   localparam int NI = 16;
   localparam int IB = 6;
   localparam int WB = 6;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic in_valid = 1'b0;
   logic out_ready = 1'b1;
   logic [NI*IB-1:0] inputs = '0;
   logic [NI*WB-1:0] weights = '0;
   logic [WB-1:0]    bias = '0;

   int n_cmp = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   node_seq_if #(.OUTPUT_BITS(1)) if_a ();
   node_seq_if #(.OUTPUT_BITS(1)) if_l1 ();
   node_seq_if #(.OUTPUT_BITS(1)) if_l16 ();
   node_seq_if #(.OUTPUT_BITS(4)) if_o4 ();

   assign if_a.in_valid   = in_valid;  assign if_a.out_ready   = out_ready;
   assign if_a.inputs_t   = inputs;    assign if_a.weights_t   = weights;   assign if_a.bias_t   = bias;
   assign if_l1.in_valid  = in_valid;  assign if_l1.out_ready  = out_ready;
   assign if_l1.inputs_t  = inputs;    assign if_l1.weights_t  = weights;   assign if_l1.bias_t  = bias;
   assign if_l16.in_valid = in_valid;  assign if_l16.out_ready = out_ready;
   assign if_l16.inputs_t = inputs;    assign if_l16.weights_t = weights;   assign if_l16.bias_t = bias;
   assign if_o4.in_valid  = in_valid;  assign if_o4.out_ready  = out_ready;
   assign if_o4.inputs_t  = inputs;    assign if_o4.weights_t  = weights;   assign if_o4.bias_t  = bias;

   node_seq                                     dut_a   (.clk(clk), .reset(reset), .bus(if_a));
   node_seq #(.LANES(1))                        dut_l1  (.clk(clk), .reset(reset), .bus(if_l1));
   node_seq #(.LANES(16))                       dut_l16 (.clk(clk), .reset(reset), .bus(if_l16));
   node_seq #(.OUTPUT_BITS(4), .OUT_SHIFT(2))   dut_o4  (.clk(clk), .reset(reset), .bus(if_o4));

   task automatic chk(input string nm, input int got, input int want);
      n_cmp++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, got, want);
      end
   endtask

   function automatic logic [NI*IB-1:0] uni(input int v);
      logic [NI*IB-1:0] r;
      for (int i = 0; i < NI; i++) r[i*IB +: IB] = v[IB-1:0];
      return r;
   endfunction

   function automatic int model_sum(input logic [NI*IB-1:0] iv, input logic [NI*WB-1:0] wv,
                                    input logic [WB-1:0] bv);
      int s;
      logic [15:0] t;
      s = int'($signed(bv));
      for (int i = 0; i < NI; i++)
         s += int'($signed(iv[i*IB +: IB])) * int'($signed(wv[i*WB +: WB]));
      t = 16'(s);
      return int'($signed(t));
   endfunction

   function automatic int model_act4(input int s);
      int v;
      v = s >>> 2;
      if (v > 7)  v = 7;
      if (v < -8) v = -8;
      return v;
   endfunction

   task automatic run_vec(input string nm, input logic [NI*IB-1:0] iv, input logic [NI*WB-1:0] wv,
                          input logic [WB-1:0] bv, input int es, input int e1, input int e4);
      int lat_a = 0, lat_l1 = 0, lat_l16 = 0, lat_o4 = 0;
      int s_a = 0, o_a = 0, s_l1 = 0, s_l16 = 0, s_o4 = 0, o_o4 = 0;
      @(negedge clk);
      inputs = iv; weights = wv; bias = bv; in_valid = 1'b1;
      chk({nm, " in_ready"}, int'(if_a.in_ready), 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      inputs  = {$urandom(), $urandom(), $urandom()};
      weights = {$urandom(), $urandom(), $urandom()};
      bias    = WB'($urandom());
      for (int cyc = 1; cyc <= 24; cyc++) begin
         @(posedge clk); #1;
         if (if_a.out_valid && lat_a == 0) begin
            lat_a = cyc; s_a = int'($signed(if_a.sum_out)); o_a = int'(if_a.outputs_t);
         end
         if (if_l1.out_valid && lat_l1 == 0) begin
            lat_l1 = cyc; s_l1 = int'($signed(if_l1.sum_out));
         end
         if (if_l16.out_valid && lat_l16 == 0) begin
            lat_l16 = cyc; s_l16 = int'($signed(if_l16.sum_out));
         end
         if (if_o4.out_valid && lat_o4 == 0) begin
            lat_o4 = cyc; s_o4 = int'($signed(if_o4.sum_out)); o_o4 = int'(if_o4.outputs_t);
         end
      end
      chk({nm, " sum"}, s_a, es);
      chk({nm, " act1"}, o_a, e1);
      chk({nm, " latency"}, lat_a, 4);
      chk({nm, " lanes1 sum"}, s_l1, es);
      chk({nm, " lanes1 latency"}, lat_l1, 16);
      chk({nm, " lanes16 sum"}, s_l16, es);
      chk({nm, " lanes16 latency"}, lat_l16, 1);
      chk({nm, " o4 sum"}, s_o4, es);
      chk({nm, " o4 act"}, o_o4, e4 & 15);
   endtask

   typedef struct {
      string nm;
      int    iv;
      int    wv;
      int    bv;
      int    es;
      int    e1;
      int    e4;
   } vec_t;

   vec_t tbl[6];

   initial begin
      int got_valid;
      int any_valid;
      logic [NI*IB-1:0] riv;
      logic [NI*WB-1:0] rwv;
      logic [WB-1:0]    rbv;
      int rs;

      tbl[0] = '{"ones",      1,   1,   0,    16, 1,  4};
      tbl[1] = '{"max_neg", -32, -32, -32, 16352, 1,  7};
      tbl[2] = '{"neg",       1,  -1,   0,   -16, 0, -4};
      tbl[3] = '{"zero",      5,   0,   0,     0, 1,  0};
      tbl[4] = '{"sat_hi",    1,   6,   4,   100, 1,  7};
      tbl[5] = '{"sat_lo",    1,  -6,  -4,  -100, 0, -8};

      #1;
      chk("reset in_ready", int'(if_a.in_ready), 0);
      chk("reset out_valid", int'(if_a.out_valid), 0);
      chk("reset sum_out", int'(if_a.sum_out), 0);
      chk("reset outputs_t", int'(if_a.outputs_t), 0);
      chk("reset o4 outputs_t", int'(if_o4.outputs_t), 0);
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1'b0;

      for (int i = 0; i < 6; i++)
         run_vec(tbl[i].nm, uni(tbl[i].iv), uni(tbl[i].wv), WB'(tbl[i].bv),
                 tbl[i].es, tbl[i].e1, tbl[i].e4);

      // Backpressure: hold the result, pulse in_valid while stalled.
      out_ready = 1'b0;
      @(negedge clk);
      inputs = uni(1); weights = uni(1); bias = '0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      got_valid = 0;
      for (int c = 0; c < 10 && got_valid == 0; c++) begin
         @(posedge clk); #1;
         if (if_a.out_valid) got_valid = 1;
      end
      chk("bp out_valid rise", got_valid, 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         inputs = uni(-1); weights = uni(1); bias = '0; in_valid = (i == 2);
         @(posedge clk); #1;
         chk("bp out_valid held", int'(if_a.out_valid), 1);
         chk("bp sum held", int'($signed(if_a.sum_out)), 16);
         chk("bp act held", int'(if_a.outputs_t), 1);
         chk("bp in_ready low", int'(if_a.in_ready), 0);
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp release out_valid", int'(if_a.out_valid), 0);
      chk("bp release in_ready", int'(if_a.in_ready), 1);
      repeat (20) @(posedge clk);
      #1;
      chk("bp pulse ignored sum", int'($signed(if_a.sum_out)), 16);
      chk("bp pulse ignored valid", int'(if_a.out_valid), 0);

      // Reset in the second accumulate beat discards the partial sum.
      @(negedge clk);
      inputs = uni(1); weights = uni(-1); bias = '0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      chk("rst out_valid", int'(if_a.out_valid), 0);
      chk("rst sum_out", int'(if_a.sum_out), 0);
      chk("rst outputs_t", int'(if_a.outputs_t), 0);
      chk("rst in_ready", int'(if_a.in_ready), 0);
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1'b0;
      any_valid = 0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         if (if_a.out_valid || if_l1.out_valid || if_l16.out_valid || if_o4.out_valid) any_valid = 1;
      end
      chk("rst no output pulse", any_valid, 0);
      run_vec("after_rst", uni(2), uni(3), WB'(1), 97, 1, 7);

      for (int n = 0; n < 20; n++) begin
         riv = {$urandom(), $urandom(), $urandom()};
         rwv = {$urandom(), $urandom(), $urandom()};
         rbv = WB'($urandom());
         rs  = model_sum(riv, rwv, rbv);
         run_vec($sformatf("rand%0d", n), riv, rwv, rbv, rs, (rs >= 0) ? 1 : 0, model_act4(rs));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
